frame_store: RTL and testbench

Pixel sink and readback for the sprite pipeline. It accepts the `x/y/color/plot` pixel-write stream produced by the sprite drawing datapath and stores it in a 160x120, 3-bit-colour frame buffer. It can stream the frame back out in raster order over a valid/ready handshake. It also answers single-pixel probe queries that the game controller uses for collision detection.

---
 rtl/frame_store.sv | 182 ++++++++++++++++++
 tb/tb_frame_store.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_store.sv
// frame_store: 160x120x3 frame buffer fed by the sprite pixel stream, with raster scan-out and single-pixel probe.
// Latency: first scan pixel 2 cycles after scan_start, then 1 pixel/cycle; probe result 1 cycle after probe_req.
// Backpressure: scan outputs hold while scan_valid & !scan_ready; no new read is issued until the pixel is taken.
module frame_store #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         x_in,
  input  logic [7:0]         y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               plot,
  input  logic               clear,
  input  logic               scan_start,
  output logic               busy,
  output logic [7:0]         scan_x_out,
  output logic [7:0]         scan_y_out,
  output logic [COLOR_W-1:0] scan_color_out,
  output logic               scan_valid,
  input  logic               scan_ready,
  output logic               scan_done,
  input  logic [7:0]         probe_x,
  input  logic [7:0]         probe_y,
  input  logic               probe_req,
  output logic [COLOR_W-1:0] probe_color,
  output logic               probe_ack
);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [7:0] W8   = 8'(WIDTH);
  localparam logic [7:0] H8   = 8'(HEIGHT);
  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [7:0] YMAX = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCAN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  // Pixel storage; deliberately not reset, the CLEAR sweep initialises it.
  logic [COLOR_W-1:0] mem [DEPTH];

  // Scan read-issue position (next pixel to fetch).
  logic [AW-1:0] rd_addr_q;
  logic [7:0]    rd_x_q, rd_y_q;
  logic          rd_left_q;

  // Presented scan pixel and probe result registers.
  logic [7:0]         scan_x_q, scan_y_q;
  logic [COLOR_W-1:0] scan_color_q;
  logic               scan_valid_q;
  logic [COLOR_W-1:0] probe_color_q;
  logic               probe_ack_q;

  logic               scan_accept, scan_last, scan_issue;
  logic               pix_ok, wr_en, probe_ok;
  logic [AW-1:0]      pix_addr, wr_addr, probe_addr;
  logic [COLOR_W-1:0] wr_dat;

  assign pix_addr   = AW'(y_in) * AW'(WIDTH) + AW'(x_in);
  assign probe_addr = AW'(probe_y) * AW'(WIDTH) + AW'(probe_x);
  assign probe_ok   = (probe_x < W8) && (probe_y < H8);

  // Range check before forming the address so out-of-range coordinates can never alias.
  assign pix_ok  = plot && (x_in < W8) && (y_in < H8) && (state_q != S_CLEAR);
  assign wr_en   = (state_q == S_CLEAR) || pix_ok;
  assign wr_addr = (state_q == S_CLEAR) ? clr_addr_q : pix_addr;
  assign wr_dat  = (state_q == S_CLEAR) ? '0 : color_in;

  assign scan_accept = scan_valid_q && scan_ready;
  assign scan_last   = (state_q == S_SCAN) && scan_accept &&
                       (scan_x_q == XMAX) && (scan_y_q == YMAX);
  assign scan_issue  = (state_q == S_SCAN) && rd_left_q && (!scan_valid_q || scan_ready);

  // Next-state: CLEAR sweeps every address once; clear beats scan_start in IDLE.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clear) begin
          clr_addr_d = '0;
          state_d    = S_CLEAR;
        end else if (scan_start) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_last) state_d = S_IDLE;
      end
      default: begin
        clr_addr_d = '0;
        state_d    = S_CLEAR;
      end
    endcase
  end

  // State register; reset lands in CLEAR at address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Single write port shared by the clear sweep and the pixel stream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Scan: advance the raster on each issued read; read data loads the output register directly (old data on collision).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q    <= '0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      rd_left_q    <= 1'b1;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      scan_color_q <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      if (state_q != S_SCAN) begin
        rd_addr_q <= '0;
        rd_x_q    <= '0;
        rd_y_q    <= '0;
        rd_left_q <= 1'b1;
      end else if (scan_issue) begin
        rd_addr_q <= rd_addr_q + AW'(1);
        if (rd_x_q == XMAX) begin
          rd_x_q <= '0;
          rd_y_q <= rd_y_q + 8'd1;
        end else begin
          rd_x_q <= rd_x_q + 8'd1;
        end
        if ((rd_x_q == XMAX) && (rd_y_q == YMAX)) rd_left_q <= 1'b0;
      end
      if (scan_issue) begin
        scan_color_q <= mem[rd_addr_q];
        scan_x_q     <= rd_x_q;
        scan_y_q     <= rd_y_q;
        scan_valid_q <= 1'b1;
      end else if (scan_accept) begin
        scan_valid_q <= 1'b0;
      end
    end
  end

  // Probe: one-cycle read in any state; result register holds between acks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      probe_color_q <= '0;
      probe_ack_q   <= 1'b0;
    end else begin
      probe_ack_q <= probe_req;
      if (probe_req) probe_color_q <= probe_ok ? mem[probe_addr] : '0;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign scan_x_out     = scan_x_q;
  assign scan_y_out     = scan_y_q;
  assign scan_color_out = scan_color_q;
  assign scan_valid     = scan_valid_q;
  assign scan_done      = scan_last;
  assign probe_color    = probe_color_q;
  assign probe_ack      = probe_ack_q;

endmodule

// File: tb/tb_frame_store.sv
// tb_frame_store: self-checking bench for frame_store against a pixel-array reference model.
// Latency: exercises clear duration, probe 1-cycle ack, scan 2-cycle start and per-beat ordering.
// Backpressure: drives randomized scan_ready and checks outputs hold while stalled.
module tb_frame_store;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] x_in = '0;
  logic [7:0] y_in = '0;
  logic [2:0] color_in = '0;
  logic       plot = 1'b0;
  logic       clear = 1'b0;
  logic       scan_start = 1'b0;
  logic       scan_ready = 1'b0;
  logic [7:0] probe_x = '0;
  logic [7:0] probe_y = '0;
  logic       probe_req = 1'b0;
  logic       busy;
  logic [7:0] scan_x_out, scan_y_out;
  logic [2:0] scan_color_out;
  logic       scan_valid, scan_done;
  logic [2:0] probe_color;
  logic       probe_ack;

  frame_store #(.WIDTH(W), .HEIGHT(H), .COLOR_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .plot(plot),
    .clear(clear), .scan_start(scan_start), .busy(busy),
    .scan_x_out(scan_x_out), .scan_y_out(scan_y_out), .scan_color_out(scan_color_out),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_done(scan_done),
    .probe_x(probe_x), .probe_y(probe_y), .probe_req(probe_req),
    .probe_color(probe_color), .probe_ack(probe_ack)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int pexp = 0;

  // Reference picture: plain array of colours, raster index y*W+x.
  logic [2:0] model [N];
  logic [2:0] snap  [N];

  typedef struct {
    int px; int py; int pc; bit pl;
    int qx; int qy; int want;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input int got, input int want);
    ncmp++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] idx(input int x, input int y);
    return 15'(y * W + x);
  endfunction

  function automatic bit on_screen(input int x, input int y);
    return (x >= 0) && (x < W) && (y >= 0) && (y < H);
  endfunction

  function automatic int model_rd(input int x, input int y);
    if (!on_screen(x, y)) return 0;
    return int'(model[idx(x, y)]);
  endfunction

  task automatic model_zero();
    for (int i = 0; i < N; i++) model[15'(i)] = '0;
  endtask

  // Drive a pixel write for the coming edge and record it in the model if it should land.
  task automatic drive_plot(input int x, input int y, input int c, input bit pl);
    x_in = 8'(x); y_in = 8'(y); color_in = 3'(c); plot = pl;
    if (pl && on_screen(x, y)) model[idx(x, y)] = 3'(c);
  endtask

  task automatic do_probe(input string nm, input int x, input int y, input int want);
    probe_x = 8'(x); probe_y = 8'(y); probe_req = 1'b1;
    step();
    probe_req = 1'b0;
    chk({nm, "_ack"}, int'(probe_ack), 1);
    chk({nm, "_color"}, int'(probe_color), want);
    step();
    chk({nm, "_ack_pulse"}, int'(probe_ack), 0);
    chk({nm, "_hold"}, int'(probe_color), want);
    pexp = want;
  endtask

  // Called right after reset release: busy must stay high for exactly N cycles.
  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 25000) begin
      step();
      n++;
    end
    chk(nm, n, N);
  endtask

  function automatic int rnd_x();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(150, 200));
    return int'($urandom_range(0, 7));
  endfunction

  function automatic int rnd_y();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(110, 140));
    return int'($urandom_range(0, 7));
  endfunction

  // One raster pass; rdy_pct = chance of scan_ready, rst_beat>0 asserts reset after that many beats.
  task automatic run_scan(input string nm, input int rdy_pct, input int rst_beat, input bit corners);
    int  beat, cyc;
    bit  stalled, aborted, clr_sent;
    int  sx, sy, sc;
    beat = 0; cyc = 0; stalled = 0; aborted = 0; clr_sent = 0;
    sx = 0; sy = 0; sc = 0;
    snap = model;
    scan_ready = 1'b1; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    chk({nm, "_lat_edge1_valid"}, int'(scan_valid), 0);
    chk({nm, "_busy_on_entry"}, int'(busy), 1);
    step();
    chk({nm, "_lat_edge2_valid"}, int'(scan_valid), 1);
    while (beat < N && cyc < 60000) begin
      plot = 1'b0; clear = 1'b0;
      scan_ready = ($urandom_range(0, 99) < rdy_pct);
      if (corners && beat == 3531) begin
        // Presented beat 3531 while beat 3532 = (12,22) is being read: write lands the same edge.
        scan_ready = 1'b1;
        drive_plot(12, 22, 5, 1'b1);
      end
      if (corners && beat == 8000 && !clr_sent) begin
        clear = 1'b1;
        clr_sent = 1;
      end
      #1;
      chk({nm, "_busy"}, int'(busy), 1);
      chk({nm, "_valid"}, int'(scan_valid), 1);
      if (stalled) begin
        chk({nm, "_stall_x"}, int'(scan_x_out), sx);
        chk({nm, "_stall_y"}, int'(scan_y_out), sy);
        chk({nm, "_stall_c"}, int'(scan_color_out), sc);
      end
      if (scan_valid && scan_ready) begin
        chk({nm, "_x"}, int'(scan_x_out), beat % W);
        chk({nm, "_y"}, int'(scan_y_out), beat / W);
        chk({nm, "_color"}, int'(scan_color_out), int'(snap[15'(beat)]));
        chk({nm, "_done"}, int'(scan_done), (beat == N - 1) ? 1 : 0);
        beat++;
        stalled = 0;
      end else begin
        chk({nm, "_done_idle"}, int'(scan_done), 0);
        stalled = 1;
        sx = int'(scan_x_out); sy = int'(scan_y_out); sc = int'(scan_color_out);
      end
      if (rst_beat > 0 && beat == rst_beat) begin
        reset_n = 1'b0;
        #1;
        chk({nm, "_rst_valid"}, int'(scan_valid), 0);
        chk({nm, "_rst_busy"}, int'(busy), 1);
        chk({nm, "_rst_x"}, int'(scan_x_out), 0);
        chk({nm, "_rst_y"}, int'(scan_y_out), 0);
        chk({nm, "_rst_color"}, int'(scan_color_out), 0);
        chk({nm, "_rst_done"}, int'(scan_done), 0);
        aborted = 1;
        break;
      end
      step();
      cyc++;
    end
    plot = 1'b0; clear = 1'b0; scan_ready = 1'b0;
    if (!aborted) begin
      chk({nm, "_beats"}, beat, N);
      chk({nm, "_valid_after"}, int'(scan_valid), 0);
      chk({nm, "_busy_after"}, int'(busy), 0);
    end
  endtask

  initial begin
    #1200000;
    nerr++;
    $display("FAIL global_timeout: simulation still running, want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $fatal(1, "bench timeout");
  end

  initial begin
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 1);
    chk("rst_scan_valid", int'(scan_valid), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    chk("rst_probe_ack", int'(probe_ack), 0);
    chk("rst_scan_x", int'(scan_x_out), 0);
    chk("rst_scan_y", int'(scan_y_out), 0);
    chk("rst_scan_color", int'(scan_color_out), 0);
    chk("rst_probe_color", int'(probe_color), 0);
    reset_n = 1'b1;
    wait_clear("clear_after_reset");
    do_probe("init_0_0", 0, 0, 0);
    do_probe("init_80_60", 80, 60, 0);
    do_probe("init_159_119", 159, 119, 0);

    // Write then probe the next cycle.
    vecs[0] = '{px: 3,   py: 4,   pc: 7, pl: 1'b1, qx: 3,   qy: 4,   want: 7};
    vecs[1] = '{px: 160, py: 5,   pc: 7, pl: 1'b1, qx: 0,   qy: 6,   want: 0};
    vecs[2] = '{px: 160, py: 5,   pc: 7, pl: 1'b1, qx: 160, qy: 5,   want: 0};
    vecs[3] = '{px: 159, py: 119, pc: 6, pl: 1'b1, qx: 159, qy: 119, want: 6};
    vecs[4] = '{px: 0,   py: 120, pc: 5, pl: 1'b1, qx: 0,   qy: 0,   want: 0};
    vecs[5] = '{px: 255, py: 255, pc: 3, pl: 1'b1, qx: 255, qy: 255, want: 0};
    vecs[6] = '{px: 3,   py: 4,   pc: 2, pl: 1'b0, qx: 3,   qy: 4,   want: 7};
    vecs[7] = '{px: 80,  py: 60,  pc: 1, pl: 1'b1, qx: 80,  qy: 61,  want: 0};
    vecs[8] = '{px: 0,   py: 0,   pc: 0, pl: 1'b0, qx: 80,  qy: 60,  want: 1};
    for (int i = 0; i < 9; i++) begin
      drive_plot(vecs[i].px, vecs[i].py, vecs[i].pc, vecs[i].pl);
      step();
      plot = 1'b0;
      do_probe($sformatf("vec%0d", i), vecs[i].qx, vecs[i].qy, vecs[i].want);
    end

    // Random writes and probes against the model; a same-edge probe sees the old colour.
    for (int i = 0; i < 400; i++) begin
      int wx, wy, wc, qx, qy;
      bit wp, qr;
      wx = rnd_x(); wy = rnd_y(); wc = int'($urandom_range(0, 7));
      wp = ($urandom_range(0, 1) == 1);
      qx = rnd_x(); qy = rnd_y();
      qr = ($urandom_range(0, 1) == 1);
      if (qr) pexp = model_rd(qx, qy);
      probe_x = 8'(qx); probe_y = 8'(qy); probe_req = qr;
      drive_plot(wx, wy, wc, wp);
      step();
      chk("rnd_probe_ack", int'(probe_ack), qr ? 1 : 0);
      chk("rnd_probe_color", int'(probe_color), pexp);
    end
    probe_req = 1'b0; plot = 1'b0;

    // 5x5 pattern at (10,20).
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 5; i++) begin
        drive_plot(10 + i, 20 + j, ((2 * i + j) % 6) + 1, 1'b1);
        step();
      end
    end
    plot = 1'b0;
    do_probe("pattern_corner", 10, 20, 1);

    run_scan("scan_full", 100, 0, 1'b1);
    do_probe("rdw_after_scan", 12, 22, 5);

    run_scan("scan_bp", 70, 5000, 1'b0);
    step();
    step();
    chk("reset_hold_busy", int'(busy), 1);
    chk("reset_hold_ack", int'(probe_ack), 0);
    reset_n = 1'b1;
    wait_clear("clear_after_midscan_reset");
    model_zero();
    do_probe("post_0_0", 0, 0, 0);
    do_probe("post_3_4", 3, 4, 0);
    do_probe("post_12_22", 12, 22, 0);
    do_probe("post_159_119", 159, 119, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
